// File: rtl/if_stage_pkg.sv
// Shared CPU defines for the fetch path: instruction width, NOP word, reset PC,
// FSM state encoding and small PC helpers.
package if_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Branch targets are word addresses; low bits from ID are not trusted.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears it, stall holds it, squash captures a
// bubble that still carries the PC.
import if_stage_pkg::*;

module if_id_reg (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              squash,
  input  logic [31:0]       pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [31:0]       id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  logic [31:0]       id_pc_d,    id_pc_q;
  logic [INST_W-1:0] id_inst_d,  id_inst_q;
  logic              id_valid_d, id_valid_q;

  // Next-state selection with flush over stall over squash over capture.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_pc_d    = 32'h0000_0000;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end else if (squash) begin
      id_pc_d    = pc_i;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else begin
      id_pc_d    = pc_i;
      id_inst_d  = inst_i;
      id_valid_d = 1'b1;
    end
  end

  // Register update with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC FSM, ROM interface and IF/ID register.
// Optional macro IF_BRANCH_DELAY_SLOT_EN keeps the instruction after a taken branch.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_i,
  output logic              rom_ce,
  output logic [31:0]       rom_addr,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [31:0]       id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  logic [0:0]  state_d, state_q;
  logic [31:0] pc_d,    pc_q;
  logic        rom_ce_s;
  logic        squash_s;

  assign rom_ce_s = (state_q == S_FETCH);

  // FSM and PC selection; IDLE parks the PC on the reset vector.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        pc_d    = RESET_PC;
      end
      S_FETCH: begin
        state_d = S_FETCH;
        if (flush) begin
          pc_d = new_pc;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_flag_i) begin
          pc_d = align_word(branch_target_i);
        end else begin
          pc_d = seq_pc(pc_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IF_BRANCH_DELAY_SLOT_EN
  assign squash_s = ~rom_ce_s;
`else
  assign squash_s = ~rom_ce_s | branch_flag_i;
`endif

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .squash   (squash_s),
    .pc_i     (pc_q),
    .inst_i   (rom_data_i),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

  assign rom_ce   = rom_ce_s;
  assign rom_addr = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset release, stall, branch, flush, wrap, mid-run reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_flag_i;
  logic [31:0] new_pc, branch_target_i;

  logic        rom_ce0, rom_ce1, id_valid0, id_valid1;
  logic [31:0] rom_addr0, rom_addr1, rom_data0, rom_data1;
  logic [31:0] id_pc0, id_pc1, id_inst0, id_inst1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign rom_data0 = rom_fn(rom_addr0);
  assign rom_data1 = rom_fn(rom_addr1);

  if_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .rom_ce(rom_ce0), .rom_addr(rom_addr0), .rom_data_i(rom_data0),
    .id_pc(id_pc0), .id_inst(id_inst0), .id_valid(id_valid0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .rom_ce(rom_ce1), .rom_addr(rom_addr1), .rom_data_i(rom_data1),
    .id_pc(id_pc1), .id_inst(id_inst1), .id_valid(id_valid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic valid);
    check({tag, "_id_pc"}, id_pc0, pc);
    check({tag, "_id_inst"}, id_inst0, inst);
    check({tag, "_id_valid"}, {31'd0, id_valid0}, {31'd0, valid});
  endtask

  logic        slot_valid;
  logic [31:0] slot_inst;

  initial begin
`ifdef IF_BRANCH_DELAY_SLOT_EN
    slot_valid = 1'b1;
    slot_inst  = 32'hC0DE_0010;
`else
    slot_valid = 1'b0;
    slot_inst  = 32'h0000_0000;
`endif
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag_i = 1'b0;
    new_pc = 32'h0; branch_target_i = 32'h0;
    #1;
    check("rst_rom_ce", {31'd0, rom_ce0}, 32'd0);
    check("rst_rom_addr", rom_addr0, 32'h0);
    check_id("rst", 32'h0, 32'h0, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("rel_rom_ce0", {31'd0, rom_ce0}, 32'd0);
    tick();
    check("rel_rom_ce1", {31'd0, rom_ce0}, 32'd1);
    check("rel_addr0", rom_addr0, 32'h0);
    check("wrap_addr0", rom_addr1, 32'hFFFF_FFFC);
    tick();
    check("rel_addr4", rom_addr0, 32'h4);
    check_id("rel1", 32'h0, 32'hC0DE_0000, 1'b1);
    check("wrap_addr1", rom_addr1, 32'h0000_0000);
    check("wrap_id_pc", id_pc1, 32'hFFFF_FFFC);
    tick();
    check("rel_addr8", rom_addr0, 32'h8);
    check_id("rel2", 32'h4, 32'hC0DE_0004, 1'b1);

    // Stall three cycles at PC=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", rom_addr0, 32'h8);
      check_id("stall", 32'h4, 32'hC0DE_0004, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("resume_addr", rom_addr0, 32'hC);
    check_id("resume", 32'h8, 32'hC0DE_0008, 1'b1);
    tick();
    check("pc10_addr", rom_addr0, 32'h10);

    // Branch held off by stall, then taken; target low bits ignored.
    branch_flag_i = 1'b1; branch_target_i = 32'h43; stall = 1'b1;
    tick();
    check("brstall_addr", rom_addr0, 32'h10);
    check_id("brstall", 32'hC, 32'hC0DE_000C, 1'b1);
    stall = 1'b0;
    tick();
    check("br_addr", rom_addr0, 32'h40);
    check_id("br_slot", 32'h10, slot_inst, slot_valid);
    branch_flag_i = 1'b0;
    tick();
    check("br_next_addr", rom_addr0, 32'h44);
    check_id("br_next", 32'h40, 32'hC0DE_0040, 1'b1);

    // Flush wins over stall and branch.
    flush = 1'b1; stall = 1'b1; new_pc = 32'h180;
    branch_flag_i = 1'b1; branch_target_i = 32'h200;
    tick();
    check("flush_addr", rom_addr0, 32'h180);
    check("flush_inst", id_inst0, 32'h0);
    check("flush_valid", {31'd0, id_valid0}, 32'd0);
    flush = 1'b0; stall = 1'b0; branch_flag_i = 1'b0;
    tick();
    check("postflush_addr", rom_addr0, 32'h184);
    check_id("postflush", 32'h180, 32'hC0DE_0180, 1'b1);

    // Reset asserted during a branch cycle.
    branch_flag_i = 1'b1; branch_target_i = 32'h300;
    rst = 1'b0;
    #1;
    check("mrst_rom_ce", {31'd0, rom_ce0}, 32'd0);
    check("mrst_addr", rom_addr0, 32'h0);
    check_id("mrst", 32'h0, 32'h0, 1'b0);
    tick();
    check("mrst_hold_addr", rom_addr0, 32'h0);
    rst = 1'b1; branch_flag_i = 1'b0;
    #1;
    check("mrel_rom_ce0", {31'd0, rom_ce0}, 32'd0);
    tick();
    check("mrel_rom_ce1", {31'd0, rom_ce0}, 32'd1);
    check("mrel_addr0", rom_addr0, 32'h0);
    tick();
    check("mrel_addr4", rom_addr0, 32'h4);
    check_id("mrel", 32'h0, 32'hC0DE_0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-005 SHALL have port flush  input  1  exception flush; redirect to new_pc.
REQ-006 SHALL have port new_pc  input  32  flush target.
REQ-007 SHALL have port branch_flag_i  input  1  taken branch/jump resolved in ID this cycle.
REQ-008 SHALL have port branch_target_i  input  32  branch destination.
REQ-009 SHALL have port rom_ce  output  1  instruction ROM enable.
REQ-010 SHALL have port rom_addr  output  32  fetch address, equal to the current PC.
REQ-011 SHALL have port rom_data_i  input  32  instruction word, combinational same-cycle read.
REQ-012 SHALL have ports id_pc, id_inst (output, 32 each) and id_valid (output, 1): IF/ID register contents.

Function
REQ-013 SHALL implement a two-state FSM: S_IDLE (rom_ce=0), S_FETCH (rom_ce=1).
REQ-014 SHALL move S_IDLE->S_FETCH on the first clock edge after rst deasserts; S_FETCH SHALL leave only on reset.
REQ-015 SHALL hold PC=RESET_PC throughout S_IDLE.
REQ-016 SHALL select next PC in S_FETCH with priority flush > stall > branch_flag_i > PC+4.
REQ-017 SHALL apply 32-bit modulo arithmetic to PC+4 (32'hFFFFFFFC wraps to 0).
REQ-018 SHALL, on flush, load new_pc into PC and clear the IF/ID register (id_valid=0, id_inst=0) regardless of stall.
REQ-019 SHALL, on stall without flush, hold PC, id_pc, id_inst and id_valid unchanged and ignore branch_flag_i; ID re-presents the branch after the stall.
REQ-020 SHALL otherwise capture {PC, rom_data_i, 1} into {id_pc, id_inst, id_valid}; latency from PC to id_inst is exactly one cycle.
REQ-021 SHALL capture id_valid=0 and id_inst=0 on any edge where rom_ce=0.
REQ-022 SHALL treat branch_target_i as word-aligned and SHALL ignore its bits [1:0], forcing them to 0.

Reset
REQ-023 SHALL, while rst=0, force state=S_IDLE, PC=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_valid=0 asynchronously.
REQ-024 SHALL, when reset is asserted mid-fetch, discard the in-flight instruction and any pending redirect.

Configuration
REQ-025 SHALL support macro IF_BRANCH_DELAY_SLOT_EN.
REQ-026 With the macro defined, the instruction fetched in the cycle branch_flag_i=1 (delay slot) SHALL be captured normally with id_valid=1.
REQ-027 Without the macro, that instruction SHALL be squashed: id_inst=0, id_valid=0 captured on that edge.

Structure
REQ-028 SHALL take the NOP word, the reset PC, the instruction width and the FSM state encoding from the shared CPU defines package.
REQ-029 SHALL place the IF/ID register in sub-module if_id_reg (ports: clk, rst, stall, flush, squash, pc_i, inst_i, and id_* outputs).

Verification
REQ-030 Reset release: rst low 10 cycles then high -> rom_ce=0 for one cycle, then rom_addr=0,4,8 on consecutive cycles; id_pc=0 one cycle after rom_addr=0.
REQ-031 Taken branch: branch_flag_i=1, target 32'h40 while PC=32'h10 -> next rom_addr=32'h40; id_pc=32'h10 with id_valid=1 with the macro, id_valid=0 without it.
REQ-032 Stall: stall high 3 cycles at PC=32'h8 -> rom_addr stays 32'h8, id_* frozen; sequence resumes at 32'hC.
REQ-033 Flush and stall together: new_pc=32'h180 -> next rom_addr=32'h180, id_valid=0.
REQ-034 Wrap: RESET_PC=32'hFFFFFFFC -> second fetch address is 32'h00000000.
REQ-035 Mid-run reset: rst pulsed low during a branch cycle -> all outputs zero at once, branch lost, restart at RESET_PC.
